alu_operand_sequencer: RTL and testbench

Upstream operand-entry stage for the 4-bit lab ALU. It captures A, B and opcode from board switches, one value per push-button press, and drives them as registered ALU inputs. One cycle later it samples the ALU's combinational result and N/Z/C/V flags into hold registers for the display stage. It is a 5-state FSM with button synchronisers, edge detection and an optional debouncer.

---
 rtl/alu_operand_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Operand-entry front end for the 4-bit lab ALU. Push-button presses step
// through A, B and opcode capture from the board switches. The ALU sees the
// captured values as registered inputs. One cycle later its result and
// {N,Z,C,V} flags are latched into hold registers for the display stage.
//
// Optional feature: define ALU_SEQ_DEBOUNCE_EN to put a per-button
// stable-high counter (DEBOUNCE_CYCLES) between the synchroniser and the
// edge detector. Without the macro, the synchronised level feeds the edge
// detector directly and DEBOUNCE_CYCLES has no effect.
module alu_operand_sequencer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       op_sw,
    input  logic             btn_next,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] res_q,
    output logic [3:0]       flags_q,
    output logic             res_valid,
    output logic             err,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // Highest opcode the ALU implements; anything above is rejected.
    localparam logic [3:0] OP_MAX = 4'b1001;

    state_t state, state_next;

    logic [1:0] next_sync, clear_sync;
    logic       next_level, clear_level;
    logic       next_prev, clear_prev;
    logic       next_pulse, clear_pulse;

    logic load_a, load_b, load_op, capture, op_reject, clear_all;

    // Two-flop synchronisers; reset to 0 so a button held through reset
    // release still produces one rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_sync  <= 2'b00;
            clear_sync <= 2'b00;
        end else begin
            next_sync  <= {next_sync[0], btn_next};
            clear_sync <= {clear_sync[0], btn_clear};
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] next_cnt, clear_cnt;

    // Stable-high counters: count up while the synced level is high,
    // saturate at the threshold, clear as soon as the level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_cnt  <= '0;
            clear_cnt <= '0;
        end else begin
            if (!next_sync[1])
                next_cnt <= '0;
            else if (next_cnt != CNT_MAX)
                next_cnt <= next_cnt + 1'b1;

            if (!clear_sync[1])
                clear_cnt <= '0;
            else if (clear_cnt != CNT_MAX)
                clear_cnt <= clear_cnt + 1'b1;
        end
    end

    // Debounced level rises once the count reaches the threshold and
    // falls in the same cycle the synced level goes low.
    assign next_level  = next_sync[1]  && (next_cnt  == CNT_MAX);
    assign clear_level = clear_sync[1] && (clear_cnt == CNT_MAX);
`else
    assign next_level  = next_sync[1];
    assign clear_level = clear_sync[1];

    // Threshold only matters in the debounced build.
    if (DEBOUNCE_CYCLES < 0) begin : g_debounce_cfg_unused
    end
`endif

    // Rising-edge detectors: remember last cycle's level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_prev  <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            next_prev  <= next_level;
            clear_prev <= clear_level;
        end
    end

    assign next_pulse  = next_level  & ~next_prev;
    assign clear_pulse = clear_level & ~clear_prev;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD_A;
        else
            state <= state_next;
    end

    // Next-state and register-enable decode; clear outranks next.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        op_reject  = 1'b0;
        clear_all  = 1'b0;

        if (clear_pulse) begin
            clear_all  = 1'b1;
            state_next = LOAD_A;
        end else begin
            case (state)
                LOAD_A: begin
                    if (next_pulse) begin
                        load_a     = 1'b1;
                        state_next = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (next_pulse) begin
                        load_b     = 1'b1;
                        state_next = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (next_pulse) begin
                        if (op_sw <= OP_MAX) begin
                            load_op    = 1'b1;
                            state_next = EXEC;
                        end else begin
                            op_reject  = 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // ALU inputs were registered on the edge entering EXEC,
                    // so the combinational result has had a full cycle.
                    capture    = 1'b1;
                    state_next = SHOW;
                end
                SHOW: begin
                    // Leaving SHOW does not capture A; a further press does.
                    if (next_pulse)
                        state_next = LOAD_A;
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    // Operand, opcode and result hold registers plus the error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 4'd0;
            res_q      <= '0;
            flags_q    <= 4'd0;
            res_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= op_reject;
            if (clear_all) begin
                alu_a      <= '0;
                alu_b      <= '0;
                alu_opcode <= 4'd0;
                res_q      <= '0;
                flags_q    <= 4'd0;
                res_valid  <= 1'b0;
            end else begin
                if (load_a) begin
                    alu_a     <= sw;
                    res_valid <= 1'b0;
                end
                if (load_b)
                    alu_b <= sw;
                if (load_op)
                    alu_opcode <= op_sw;
                if (capture) begin
                    res_q     <= alu_result;
                    flags_q   <= alu_flags;
                    res_valid <= 1'b1;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer, with a small 4-bit ALU model
// closing the loop from alu_a/alu_b/alu_opcode to alu_result/alu_flags.
module tb_alu_operand_sequencer;

    localparam int WIDTH = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int LAT  = 19;
    localparam int HOLD = 22;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 4;
`endif
    localparam int GAP = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] sw = '0;
    logic [3:0]       op_sw = 4'd0;
    logic             btn_next = 1'b0;
    logic             btn_clear = 1'b0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result, res_q;
    logic [3:0]       alu_opcode, alu_flags, flags_q;
    logic             res_valid, err;
    logic [2:0]       state_o;

    int vectors = 0;
    int miscompares = 0;
    int err_cycles = 0;

    alu_operand_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw),
        .btn_next(btn_next), .btn_clear(btn_clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid),
        .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Lab ALU model: returns {N,Z,C,V, result}.
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; s = 5'd0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = ~s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd3: begin
                if (b == 4'd0) begin r = 4'd0; v = 1'b1; end
                else r = a / b;
            end
            default: r = a & b;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_opcode);

    // Count cycles with err high.
    always @(posedge clk) if (err) err_cycles <= err_cycles + 1;

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press_next(input logic [3:0] val);
        @(negedge clk);
        sw = val; op_sw = val; btn_next = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_next = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        press_next(a);
        press_next(b);
        press_next(op);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen3;
        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_state", state_o, 3'd0);
        check_vec("rst_outs", {alu_a, alu_b, alu_opcode, res_valid, err}, 16'd0);
        check_vec("rst_hold", {res_q, flags_q}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Latency of the first press (A = 3)
        sw = 4'd3; btn_next = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 check_vec("lat_before", state_o, 3'd0);
        @(posedge clk);
        #1 check_vec("lat_at", {state_o, alu_a}, {3'd1, 4'd3});
        repeat (HOLD - LAT + 1) @(negedge clk);
        btn_next = 1'b0;
        repeat (GAP) @(negedge clk);

        // 3 + 5 ADD
        press_next(4'd5);
        press_next(4'd0);
        check_vec("add_res", res_q, 4'b1000);
        check_vec("add_flags", flags_q, 4'b1001);
        check_vec("add_valid_state", {res_valid, state_o}, {1'b1, 3'd4});
        check_vec("add_ops", {alu_a, alu_b, alu_opcode}, {4'd3, 4'd5, 4'd0});

        // Leaving SHOW does not capture A
        press_next(4'd12);
        check_vec("show_exit", {state_o, alu_a, res_valid}, {3'd0, 4'd3, 1'b1});

        // 5 - 5 SUB
        enter(4'd5, 4'd5, 4'd1);
        check_vec("sub_res_flags", {res_q, flags_q}, {4'd0, 4'b0110});
        press_next(4'd0);

        // 7 / 0 DIV
        enter(4'd7, 4'd0, 4'd3);
        check_vec("div_res_flags", {res_q, flags_q}, {4'd0, 4'b0101});
        check_vec("div_state", state_o, 3'd4);
        press_next(4'd0);

        // Invalid opcode rejected
        press_next(4'd2);
        press_next(4'd1);
        err_cycles = 0;
        press_next(4'b1100);
        check_vec("err_cycles", err_cycles, 16'd1);
        check_vec("err_state", state_o, 3'd2);
        check_vec("err_opcode", alu_opcode, 4'd3);

        // Valid opcode then goes through EXEC to SHOW
        @(negedge clk);
        op_sw = 4'b0100; btn_next = 1'b1;
        seen3 = 1'b0;
        for (int i = 0; i < HOLD + GAP; i++) begin
            @(negedge clk);
            if (i == HOLD - 1) btn_next = 1'b0;
            if (state_o == 3'd3) seen3 = 1'b1;
        end
        check_vec("exec_seen", seen3, 1'b1);
        check_vec("exec_show", {state_o, alu_opcode, res_q}, {3'd4, 4'd4, 4'd0});
        press_next(4'd0);

        // Clear and next together in LOAD_B
        press_next(4'd9);
        check_vec("a9_loaded", {state_o, alu_a}, {3'd1, 4'd9});
        @(negedge clk);
        sw = 4'd6; btn_next = 1'b1; btn_clear = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_next = 1'b0; btn_clear = 1'b0;
        repeat (GAP) @(negedge clk);
        check_vec("clr_state", state_o, 3'd0);
        check_vec("clr_regs", {alu_a, alu_b, alu_opcode, res_valid}, 16'd0);
        check_vec("clr_hold", {res_q, flags_q}, 16'd0);

        // Reset during EXEC, button held through reset release
        press_next(4'd1);
        press_next(4'd2);
        @(negedge clk);
        op_sw = 4'd0; sw = 4'd11; btn_next = 1'b1;
        seen3 = 1'b0;
        for (int i = 0; i < HOLD + 5 && !seen3; i++) begin
            @(negedge clk);
            if (state_o == 3'd3) seen3 = 1'b1;
        end
        check_vec("rexec_seen", seen3, 1'b1);
        rst_n = 1'b0;
        #1;
        check_vec("rexec_state", state_o, 3'd0);
        check_vec("rexec_outs", {alu_a, alu_b, alu_opcode, res_valid, err}, 16'd0);
        check_vec("rexec_hold", {res_q, flags_q}, 16'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (HOLD + 2) @(negedge clk);
        check_vec("held_pulse", {state_o, alu_a}, {3'd1, 4'd11});
        btn_next = 1'b0;
        repeat (GAP) @(negedge clk);
        check_vec("held_once", state_o, 3'd1);

`ifdef ALU_SEQ_DEBOUNCE_EN
        // Short glitch must be ignored
        @(negedge clk);
        sw = 4'd4; btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (25) @(negedge clk);
        check_vec("glitch", {state_o, alu_b}, {3'd1, 4'd0});
        press_next(4'd4);
        check_vec("db_press", {state_o, alu_b}, {3'd2, 4'd4});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
